// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: multi-lane in-order instruction queue between fetch and
// decode. Fetch pushes up to LANES {pc, pcplus, instr} bundles per cycle into
// a DEPTH-entry circular buffer; decode sees the oldest LANES entries
// head-aligned (first-word-fall-through) and pops up to LANES per cycle.
//
// Handshake semantics:
//   Push: fetch_ready_o depends only on the registered occupancy. When it is 1,
//   the leading run of 1s in fetch_valid_i (starting at lane 0) is enqueued on
//   the rising edge. Lanes after the first 0 are ignored. When it is 0,
//   nothing is written and fetch must hold its bundle.
//   Pop: dec_valid_o[k] is 1 when at least k+1 entries are stored. dec_pop_i
//   asks to consume that many head entries on the edge. Requests beyond the
//   occupancy or beyond LANES are clamped, so an over-request never underflows.
//   Flush: empties the queue on the edge and overrides any push or pop made in
//   the same cycle.
module fetch_decode_queue #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [LANES-1:0]             fetch_valid_i,
  input  logic [LANES*XLEN-1:0]        fetch_pc_i,
  input  logic [LANES*XLEN-1:0]        fetch_pcplus_i,
  input  logic [LANES*XLEN-1:0]        fetch_instr_i,
  output logic                         fetch_ready_o,
  output logic [LANES-1:0]             dec_valid_o,
  output logic [LANES*XLEN-1:0]        dec_pc_o,
  output logic [LANES*XLEN-1:0]        dec_pcplus_o,
  output logic [LANES*XLEN-1:0]        dec_instr_o,
  input  logic [$clog2(LANES+1)-1:0]   dec_pop_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = 3*XLEN;
  // Highest occupancy at which a full LANES-wide push still fits.
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - LANES);

  // Each entry is packed as {instr, pcplus, pc}.
  logic [EW-1:0] mem [DEPTH];

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  int            push_n;
  int            pop_n;
  logic          push_run;
  logic [PW-1:0] wr_idx   [LANES];
  logic [PW-1:0] rd_idx   [LANES];
  logic [EW-1:0] rd_entry [LANES];

  // Add a small offset to a pointer and wrap at DEPTH. A single conditional
  // subtract is enough because both operands are below DEPTH, and DEPTH does
  // not have to be a power of two.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  // Accept a push only when a whole LANES-wide bundle is guaranteed to fit.
  // This depends on the registered count alone, so there is no combinational
  // path from dec_pop_i or flush.
  assign fetch_ready_o = (count_q <= READY_MAX);
  assign count_o       = count_q;

  // Push amount: the leading run of valid lanes, and only when ready.
  always_comb begin
    push_n   = 0;
    push_run = 1'b1;
    for (int j = 0; j < LANES; j++) begin
      if (push_run && fetch_valid_i[j]) push_n = j + 1;
      else                              push_run = 1'b0;
    end
    if (!fetch_ready_o) push_n = 0;
  end

  // Pop amount: the request clamped to the occupancy and to the lane count.
  always_comb begin
    pop_n = int'(dec_pop_i);
    if (pop_n > int'(count_q)) pop_n = int'(count_q);
    if (pop_n > LANES)         pop_n = LANES;
  end

  // Per-lane write and read slots relative to tail and head.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      wr_idx[k] = wrap_add(tail_q, k);
      rd_idx[k] = wrap_add(head_q, k);
    end
  end

  // Head-aligned read. Lanes beyond the occupancy show an all-zero bubble.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      dec_valid_o[k] = (int'(count_q) > k);
      rd_entry[k]    = dec_valid_o[k] ? mem[rd_idx[k]] : '0;
    end
  end

  // Unpack the head-aligned entries onto the flat decode buses.
  always_comb begin
    dec_pc_o     = '0;
    dec_pcplus_o = '0;
    dec_instr_o  = '0;
    for (int k = 0; k < LANES; k++) begin
      dec_pc_o[k*XLEN +: XLEN]     = rd_entry[k][XLEN-1:0];
      dec_pcplus_o[k*XLEN +: XLEN] = rd_entry[k][2*XLEN-1:XLEN];
      dec_instr_o[k*XLEN +: XLEN]  = rd_entry[k][3*XLEN-1:2*XLEN];
    end
  end

  // Storage write. Not reset, and suppressed during a flush, which discards
  // the same-cycle push.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int j = 0; j < LANES; j++) begin
        if (j < push_n) begin
          mem[wr_idx[j]] <= {fetch_instr_i[j*XLEN +: XLEN],
                             fetch_pcplus_i[j*XLEN +: XLEN],
                             fetch_pc_i[j*XLEN +: XLEN]};
        end
      end
    end
  end

  // Pointer and occupancy update. Flush wins over push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= wrap_add(head_q, pop_n);
      tail_q  <= wrap_add(tail_q, push_n);
      count_q <= CW'(int'(count_q) + push_n - pop_n);
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue with LANES=2, DEPTH=8, XLEN=32.
// Every bundle uses pcplus = pc + 4 and instr = pc ^ 32'h1300_0000.
module tb_fetch_decode_queue;

  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  fetch_valid_i;
  logic [63:0] fetch_pc_i;
  logic [63:0] fetch_pcplus_i;
  logic [63:0] fetch_instr_i;
  logic        fetch_ready_o;
  logic [1:0]  dec_valid_o;
  logic [63:0] dec_pc_o;
  logic [63:0] dec_pcplus_o;
  logic [63:0] dec_instr_o;
  logic [1:0]  dec_pop_i;
  logic [3:0]  count_o;

  int tests_run;
  int tests_failed;

  fetch_decode_queue #(.LANES(LANES), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .fetch_valid_i  (fetch_valid_i),
    .fetch_pc_i     (fetch_pc_i),
    .fetch_pcplus_i (fetch_pcplus_i),
    .fetch_instr_i  (fetch_instr_i),
    .fetch_ready_o  (fetch_ready_o),
    .dec_valid_o    (dec_valid_o),
    .dec_pc_o       (dec_pc_o),
    .dec_pcplus_o   (dec_pcplus_o),
    .dec_instr_o    (dec_instr_o),
    .dec_pop_i      (dec_pop_i),
    .count_o        (count_o)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus; takes effect at the next posedge.
  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [1:0] pop, input logic fl);
    fetch_valid_i  = v;
    fetch_pc_i     = {p1, p0};
    fetch_pcplus_i = {p1 + 32'd4, p0 + 32'd4};
    fetch_instr_i  = {p1 ^ 32'h1300_0000, p0 ^ 32'h1300_0000};
    dec_pop_i      = pop;
    flush          = fl;
  endtask

  // Advance past the next posedge, then return inputs to idle.
  task automatic step();
    @(posedge clk);
    #1;
    drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tests_run++;
    if (count_o !== 4'd0) begin
      tests_failed++; $display("FAIL reset_count: got %0d expected 0", count_o);
    end
    tests_run++;
    if (fetch_ready_o !== 1'b1) begin
      tests_failed++; $display("FAIL reset_ready: got %0b expected 1", fetch_ready_o);
    end
    tests_run++;
    if (dec_valid_o !== 2'b00 || dec_pc_o !== 64'h0) begin
      tests_failed++; $display("FAIL reset_outputs: valid %0b pc %0h expected 0/0", dec_valid_o, dec_pc_o);
    end
  endtask

  task automatic test_fill();
    logic [3:0] exp_cnt;
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 32'(i*8), 32'(i*8 + 4), 2'd0, 1'b0);
      step();
      exp_cnt = 4'(2*i + 2);
      tests_run++;
      if (count_o !== exp_cnt) begin
        tests_failed++; $display("FAIL fill_count%0d: got %0d expected %0d", i, count_o, exp_cnt);
      end
      tests_run++;
      if (fetch_ready_o !== (i < 3)) begin
        tests_failed++; $display("FAIL fill_ready%0d: got %0b expected %0b", i, fetch_ready_o, (i < 3));
      end
    end
    // Push while full is ignored.
    drive(2'b11, 32'h20, 32'h24, 2'd0, 1'b0);
    step();
    tests_run++;
    if (count_o !== 4'd8) begin
      tests_failed++; $display("FAIL full_push_ignored: got %0d expected 8", count_o);
    end
    tests_run++;
    if (dec_pc_o !== {32'h4, 32'h0} || dec_valid_o !== 2'b11) begin
      tests_failed++; $display("FAIL full_head: pc %0h valid %0b expected 0000000400000000/11", dec_pc_o, dec_valid_o);
    end
  endtask

  task automatic test_steady_wrap();
    logic [31:0] exp_pc;
    logic [31:0] push_pc;
    // Drain two pairs to reach count 4 with head at 0x10.
    drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    step();
    drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    step();
    tests_run++;
    if (count_o !== 4'd4 || fetch_ready_o !== 1'b1) begin
      tests_failed++; $display("FAIL steady_start: count %0d ready %0b expected 4/1", count_o, fetch_ready_o);
    end
    exp_pc  = 32'h10;
    push_pc = 32'h20;
    for (int c = 0; c < 20; c++) begin
      tests_run++;
      if (dec_pc_o[31:0] !== exp_pc || dec_pc_o[63:32] !== exp_pc + 32'd4) begin
        tests_failed++; $display("FAIL steady_pc%0d: got %0h expected %0h/%0h", c, dec_pc_o, exp_pc + 32'd4, exp_pc);
      end
      drive(2'b11, push_pc, push_pc + 32'd4, 2'd2, 1'b0);
      step();
      tests_run++;
      if (count_o !== 4'd4) begin
        tests_failed++; $display("FAIL steady_count%0d: got %0d expected 4", c, count_o);
      end
      exp_pc  = exp_pc + 32'd8;
      push_pc = push_pc + 32'd8;
    end
    // Drain what remains.
    drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    step();
    drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    step();
    tests_run++;
    if (count_o !== 4'd0 || dec_valid_o !== 2'b00) begin
      tests_failed++; $display("FAIL steady_drain: count %0d valid %0b expected 0/00", count_o, dec_valid_o);
    end
  endtask

  task automatic test_partial();
    drive(2'b01, 32'h40, 32'h44, 2'd0, 1'b0);
    tests_run++;
    if (dec_valid_o !== 2'b00) begin
      tests_failed++; $display("FAIL no_bypass: valid %0b expected 00", dec_valid_o);
    end
    step();
    tests_run++;
    if (count_o !== 4'd1 || dec_valid_o !== 2'b01) begin
      tests_failed++; $display("FAIL partial1: count %0d valid %0b expected 1/01", count_o, dec_valid_o);
    end
    tests_run++;
    if (dec_pc_o !== {32'h0, 32'h40} || dec_pcplus_o !== {32'h0, 32'h44} ||
        dec_instr_o !== {32'h0, 32'h1300_0040}) begin
      tests_failed++; $display("FAIL partial1_data: pc %0h pcplus %0h instr %0h expected lane0 40/44/13000040 lane1 0",
                               dec_pc_o, dec_pcplus_o, dec_instr_o);
    end
    drive(2'b10, 32'h4C, 32'h50, 2'd0, 1'b0);
    step();
    tests_run++;
    if (count_o !== 4'd1 || dec_valid_o !== 2'b01 || dec_pc_o !== {32'h0, 32'h40}) begin
      tests_failed++; $display("FAIL noncontig: count %0d valid %0b pc %0h expected 1/01/40", count_o, dec_valid_o, dec_pc_o);
    end
  endtask

  task automatic test_pop_clamp();
    drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    step();
    tests_run++;
    if (count_o !== 4'd0 || dec_valid_o !== 2'b00 || fetch_ready_o !== 1'b1) begin
      tests_failed++; $display("FAIL pop_clamp: count %0d valid %0b ready %0b expected 0/00/1", count_o, dec_valid_o, fetch_ready_o);
    end
    // Pop on empty must also leave everything untouched.
    drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    step();
    tests_run++;
    if (count_o !== 4'd0) begin
      tests_failed++; $display("FAIL pop_empty: count %0d expected 0", count_o);
    end
    drive(2'b11, 32'h80, 32'h84, 2'd0, 1'b0);
    step();
    tests_run++;
    if (count_o !== 4'd2 || dec_pc_o !== {32'h84, 32'h80} || dec_pcplus_o !== {32'h88, 32'h84}) begin
      tests_failed++; $display("FAIL after_clamp: count %0d pc %0h pcplus %0h expected 2/0000008400000080/0000008800000084",
                               count_o, dec_pc_o, dec_pcplus_o);
    end
  endtask

  task automatic test_flush();
    drive(2'b11, 32'h88, 32'h8C, 2'd0, 1'b0);
    step();
    drive(2'b11, 32'h90, 32'h94, 2'd0, 1'b0);
    step();
    tests_run++;
    if (count_o !== 4'd6) begin
      tests_failed++; $display("FAIL flush_setup: count %0d expected 6", count_o);
    end
    drive(2'b11, 32'hF0, 32'hF4, 2'd2, 1'b1);
    step();
    tests_run++;
    if (count_o !== 4'd0 || dec_valid_o !== 2'b00 || fetch_ready_o !== 1'b1 || dec_pc_o !== 64'h0) begin
      tests_failed++; $display("FAIL flush: count %0d valid %0b ready %0b pc %0h expected 0/00/1/0",
                               count_o, dec_valid_o, fetch_ready_o, dec_pc_o);
    end
    drive(2'b11, 32'hC0, 32'hC4, 2'd0, 1'b0);
    step();
    tests_run++;
    if (count_o !== 4'd2 || dec_pc_o !== {32'hC4, 32'hC0}) begin
      tests_failed++; $display("FAIL after_flush: count %0d pc %0h expected 2/000000c4000000c0", count_o, dec_pc_o);
    end
  endtask

  task automatic test_mid_reset();
    drive(2'b11, 32'hD0, 32'hD4, 2'd0, 1'b0);
    step();
    drive(2'b01, 32'hD8, 32'hDC, 2'd0, 1'b0);
    step();
    tests_run++;
    if (count_o !== 4'd5) begin
      tests_failed++; $display("FAIL mid_reset_setup: count %0d expected 5", count_o);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (count_o !== 4'd0 || dec_valid_o !== 2'b00 || fetch_ready_o !== 1'b1) begin
      tests_failed++; $display("FAIL mid_reset: count %0d valid %0b ready %0b expected 0/00/1", count_o, dec_valid_o, fetch_ready_o);
    end
    tests_run++;
    if (dec_pc_o !== 64'h0 || dec_pcplus_o !== 64'h0 || dec_instr_o !== 64'h0) begin
      tests_failed++; $display("FAIL mid_reset_data: pc %0h pcplus %0h instr %0h expected 0", dec_pc_o, dec_pcplus_o, dec_instr_o);
    end
    #2;
    rst = 1'b0;
    drive(2'b11, 32'hE0, 32'hE4, 2'd0, 1'b0);
    step();
    tests_run++;
    if (count_o !== 4'd2 || dec_pc_o !== {32'hE4, 32'hE0}) begin
      tests_failed++; $display("FAIL after_reset: count %0d pc %0h expected 2/000000e4000000e0", count_o, dec_pc_o);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_fill();
    test_steady_wrap();
    test_partial();
    test_pop_clamp();
    test_flush();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Parametrised multi-lane instruction queue between the fetch and decode stages. Successor to the fixed two-lane fetch/decode pipeline register.
- Fetch pushes up to LANES {PC, PCPlus, Instr} bundles per cycle; decode pops up to LANES per cycle in program order.
- Decouples fetch from decode stalls with DEPTH entries of buffering and supports a single-cycle flush for branch redirect.

Parameters:
LANES, 2, instructions pushed/popped per cycle (>=1)
DEPTH, 8, queue entries; must be >= 2*LANES, need not be a power of two
XLEN, 32, width of PC, PCPlus and instruction fields

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous flush; empties the queue
fetch_valid_i  input  LANES  per-lane push request; lane 0 = oldest
fetch_pc_i  input  LANES*XLEN  lane k occupies bits [k*XLEN +: XLEN]
fetch_pcplus_i  input  LANES*XLEN  PCPlus per lane, same packing
fetch_instr_i  input  LANES*XLEN  instruction per lane, same packing
fetch_ready_o  output  1  queue can accept a full LANES-wide push this cycle
dec_valid_o  output  LANES  lane k holds the (k+1)-th oldest entry
dec_pc_o  output  LANES*XLEN  head-aligned PCs
dec_pcplus_o  output  LANES*XLEN  head-aligned PCPlus
dec_instr_o  output  LANES*XLEN  head-aligned instructions
dec_pop_i  input  $clog2(LANES+1)  number of entries decode consumes this cycle
count_o  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- State: storage array[DEPTH] (not reset), head ptr, tail ptr, count. Pointers wrap to 0 after DEPTH-1 via compare; no power-of-two assumption.
- Reset (async assert): head=tail=count=0. Outputs: fetch_ready_o=1, dec_valid_o=0, all dec_* data=0, count_o=0. Deassertion is used synchronously by the integrator.
- fetch_ready_o = (DEPTH - count) >= LANES. Derived from registered count only; no combinational path from dec_pop_i or flush.
- Push amount = number of consecutive 1s in fetch_valid_i starting at lane 0. Lanes after the first 0 are ignored (e.g. 4'b1011 pushes 2). Push happens only when fetch_ready_o=1; otherwise 0 entries are written and fetch must hold.
- Pushed lane j is written to array[(tail+j) mod DEPTH]; tail advances by the push amount.
- Decode outputs are first-word-fall-through from storage.
  - dec_valid_o[k] = (count > k).
  - Lane k data = array[(head+k) mod DEPTH] when valid, else all-zero (bubble).
- Pop amount = min(dec_pop_i, count, LANES); over-requests are clamped. head advances by the pop amount.
- Latency: an entry pushed in cycle N appears on dec_* in cycle N+1. There is no same-cycle bypass, so an empty queue shows dec_valid_o=0 during the push cycle.
- Simultaneous push and pop: count_next = count + push - pop. Both apply in the same edge. Full throughput of LANES/cycle is sustained while count <= DEPTH-LANES.
- Full boundary: count > DEPTH-LANES drops fetch_ready_o, even if a pop is underway that cycle.
- Empty boundary: count=0 gives dec_valid_o=0; pop is clamped to 0 and head is unchanged.
- Flush has priority over push and pop: next state head=tail=count=0. The same-cycle push is discarded. Flush while empty or full gives an identical result.
- Order is strictly FIFO across wrap-around; entries are never reordered or duplicated.
- count_o reflects the registered count.

Test Plan:
- Reset mid-operation: fill 5 entries, assert rst asynchronously mid-cycle -> immediately count_o=0, dec_valid_o=2'b00, dec_* data=0, fetch_ready_o=1.
- Fill to full: push pairs PC 0x00/0x04, 0x08/0x0C, 0x10/0x14, 0x18/0x1C with no pops -> count_o=2,4,6,8.
  - fetch_ready_o=0 once count_o=8.
  - Next push with valid=2'b11 is ignored; count stays 8.
  - dec_pc_o lanes = 0x00, 0x04.
- Steady state with wrap: 20 cycles of push 2 / pop 2 from count=4 -> count_o constant 4.
  - dec_pc_o sequence strictly +8 per cycle across head/tail wrap past index 7.
- Partial and non-contiguous push: valid=2'b01 (PC 0x40) then valid=2'b10 (PC 0x50) on an empty queue -> count_o=1 then 1.
  - Only 0x40 is visible; 0x50 is never enqueued.
  - dec_valid_o=2'b01, lane 1 data=0.
- Pop clamp: count=1, dec_pop_i=2 -> count_o=0, head advances by 1, no underflow; a later push of 0x80/0x84 appears correctly at lanes 0/1.
- Flush with push and pop: count=6, flush=1 with valid=2'b11 and dec_pop_i=2 -> next cycle count_o=0, dec_valid_o=0, fetch_ready_o=1. The flushed-cycle PCs never appear.
